upc_loop_monitor: RTL and testbench
===================================

UPC_LOOP_MONITOR -- requirements
Module: upc_loop_monitor

Interface
REQ-001 Parameter STATE_W, default 1, width of the FSM state compare inputs.
REQ-002 Parameter CNT_W, default 32, width of all counters.
REQ-003 clock  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cur_state  in  STATE_W  observed loop FSM state.
REQ-006 iter_start_state, iter_end_state, quit_state  in  STATE_W each  reference states for iteration start, iteration end and quit.
REQ-007 iter_start_block, iter_end_block, quit_block  in  1 each  stall flags; 1 = blocked.
REQ-008 iter_start_enable, iter_end_enable, quit_enable  in  1 each  pipeline stage enables.
REQ-009 loop_start, loop_ready, loop_done, loop_continue  in  1 each  loop block-level handshake.
REQ-010 quit_at_end  in  1  1 = quit is counted at iteration end, not iteration start.
REQ-011 finish  in  1  end-of-simulation/run marker.
REQ-012 active  out  1  loop invocation in progress.
REQ-013 iter_start_p, iter_end_p, quit_p  out  1 each  single-cycle event strobes.
REQ-014 invocations, iter_started, iter_ended, last_latency, max_latency  out  CNT_W each  statistics.
REQ-015 inflight  out  8  started minus ended iterations.
REQ-016 stall_cycles  out  CNT_W  stalled cycles while active.
REQ-017 finished  out  1  sticky finish indication.

Function
REQ-018 Event strobes are combinational: iter_start_p = (cur_state==iter_start_state) & ~iter_start_block & iter_start_enable & active; iter_end_p and quit_p are formed analogously from their own state/block/enable.
REQ-019 With quit_at_end=1, quit_p is additionally gated by iter_end_p.
REQ-020 FSM states: IDLE, RUN, HOLD, FROZEN; active=1 in RUN and HOLD.
REQ-021 IDLE->RUN when loop_start=1; invocations increments; latency counter loads 1.
REQ-022 RUN->IDLE when loop_done & loop_continue; RUN->HOLD when loop_done & ~loop_continue; HOLD->IDLE when loop_continue.
REQ-023 On leaving RUN/HOLD to IDLE: last_latency = latency counter; max_latency = max(max_latency, latency counter).
REQ-024 Latency counter increments every cycle in RUN and HOLD.
REQ-025 iter_started increments on iter_start_p; iter_ended increments on iter_end_p; same-cycle start and end leave inflight unchanged.
REQ-026 inflight saturates at 255 and at 0; underflow attempts are ignored.
REQ-027 All counters saturate at all-ones; they never wrap.
REQ-028 finish=1 in any state -> FROZEN next cycle; finished=1; all counters and outputs hold; only reset exits FROZEN.
REQ-029 loop_start and loop_done in the same IDLE cycle: enter RUN and complete on the next cycle's evaluation; a 1-cycle invocation is recorded with last_latency=1.
REQ-030 loop_ready is ignored in this version.

Reset
REQ-031 On reset low, the FSM is IDLE and all counters, inflight, finished and active are 0, asynchronously.
REQ-032 Reset mid-invocation discards the partial latency; no statistics update.

Configuration
REQ-033 Macro UPC_LOOP_MONITOR_STALL_EN defined: stall_cycles increments each RUN cycle in which cur_state==iter_start_state & iter_start_block.
REQ-034 Macro not defined: stall_cycles is tied to 0 and its counter logic is absent.

Structure
REQ-035 A shared package upc_mon_pkg holds the FSM state enum, the saturating-increment function and CNT_W default.
REQ-036 One sub-module, sat_counter (enable, load, value, saturating), is instantiated per statistic.

Verification
REQ-037 Reset, then loop_start 1 cycle, 4 cycles of iter_start_p, loop_done at cycle 6 with loop_continue=1 -> invocations=1, iter_started=4, last_latency=6, active=0.
REQ-038 Iteration start with iter_start_block=1 for 3 cycles -> no iter_start_p; stall_cycles=3 with STALL_EN, 0 without.
REQ-039 loop_done=1, loop_continue=0 for 2 cycles, then 1 -> HOLD observed; last_latency includes the 2 hold cycles.
REQ-040 Two invocations of latency 5 then 3 -> last_latency=3, max_latency=5, invocations=2.
REQ-041 finish pulsed mid-run -> finished=1; counters constant over the next 10 cycles despite further events.
REQ-042 CNT_W=4, 20 iterations -> iter_started=15 (saturated); reset low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/upc_mon_pkg.sv
// Shared types and helpers for the upc_loop_monitor block: FSM state enum,
// default counter width and the saturating increment used by every counter.
package upc_mon_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_FROZEN = 2'd3
  } mon_state_t;

  // Width-generic: callers widen their value to 64 bits and pass their own all-ones ceiling.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] ceiling);
    return (value >= ceiling) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous load; never wraps past all-ones.
module sat_counter
  import upc_mon_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ALL_ONES = '1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable) begin
      count <= W'(sat_inc(64'(count), 64'(ALL_ONES)));
    end
  end

endmodule

// File: rtl/upc_loop_monitor.sv
// Loop invocation / iteration monitor with latency statistics and a sticky freeze.
// Optional stall counting is built when UPC_LOOP_MONITOR_STALL_EN is defined.
module upc_loop_monitor
  import upc_mon_pkg::*;
#(
  parameter int STATE_W = 1,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  input  logic               finish,
  output logic               active,
  output logic               iter_start_p,
  output logic               iter_end_p,
  output logic               quit_p,
  output logic [CNT_W-1:0]   invocations,
  output logic [CNT_W-1:0]   iter_started,
  output logic [CNT_W-1:0]   iter_ended,
  output logic [CNT_W-1:0]   last_latency,
  output logic [CNT_W-1:0]   max_latency,
  output logic [7:0]         inflight,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               finished
);

  mon_state_t       state;
  logic             pend_done;
  logic             pend_cont;
  logic [CNT_W-1:0] latency;
  logic             start_hit, end_hit, quit_hit;
  logic             live, run, done_eff, cont_eff;
  logic             begin_inv, close_inv, max_upd;
  logic             unused_ready;

  assign unused_ready = loop_ready;

  assign start_hit    = (cur_state == iter_start_state) & ~iter_start_block & iter_start_enable;
  assign end_hit      = (cur_state == iter_end_state) & ~iter_end_block & iter_end_enable;
  assign quit_hit     = (cur_state == quit_state) & ~quit_block & quit_enable;
  assign iter_start_p = start_hit & active;
  assign iter_end_p   = end_hit & active;
  assign quit_p       = quit_hit & active & (~quit_at_end | iter_end_p);

  // The finish cycle itself already freezes statistics, not only the cycles after it.
  assign live      = (state != ST_FROZEN) & ~finish;
  assign run       = (state == ST_RUN);
  // A done seen together with loop_start is replayed on the first RUN cycle.
  assign done_eff  = loop_done | pend_done;
  assign cont_eff  = pend_done ? pend_cont : loop_continue;
  assign begin_inv = live & (state == ST_IDLE) & loop_start;
  assign close_inv = live & ((run & done_eff & cont_eff) | ((state == ST_HOLD) & loop_continue));
  assign max_upd   = close_inv & (latency > max_latency);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      active    <= 1'b0;
      finished  <= 1'b0;
      pend_done <= 1'b0;
      pend_cont <= 1'b0;
    end else if (finish) begin
      state     <= ST_FROZEN;
      active    <= 1'b0;
      finished  <= 1'b1;
      pend_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (loop_start) begin
          state     <= ST_RUN;
          active    <= 1'b1;
          pend_done <= loop_done;
          pend_cont <= loop_continue;
        end
        ST_RUN: begin
          pend_done <= 1'b0;
          if (done_eff) begin
            state  <= cont_eff ? ST_IDLE : ST_HOLD;
            active <= ~cont_eff;
          end
        end
        ST_HOLD: if (loop_continue) begin
          state  <= ST_IDLE;
          active <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else if (live) begin
      if (iter_start_p & ~iter_end_p) begin
        inflight <= 8'(sat_inc(64'(inflight), 64'd255));
      end else if (iter_end_p & ~iter_start_p & (inflight != 8'd0)) begin
        inflight <= inflight - 8'd1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_latency (
    .clock(clock), .reset(reset), .enable(live & active), .load(begin_inv),
    .value(CNT_W'(1)), .count(latency)
  );

  sat_counter #(.W(CNT_W)) u_invocations (
    .clock(clock), .reset(reset), .enable(begin_inv), .load(1'b0),
    .value('0), .count(invocations)
  );

  sat_counter #(.W(CNT_W)) u_iter_started (
    .clock(clock), .reset(reset), .enable(live & iter_start_p), .load(1'b0),
    .value('0), .count(iter_started)
  );

  sat_counter #(.W(CNT_W)) u_iter_ended (
    .clock(clock), .reset(reset), .enable(live & iter_end_p), .load(1'b0),
    .value('0), .count(iter_ended)
  );

  sat_counter #(.W(CNT_W)) u_last_latency (
    .clock(clock), .reset(reset), .enable(1'b0), .load(close_inv),
    .value(latency), .count(last_latency)
  );

  sat_counter #(.W(CNT_W)) u_max_latency (
    .clock(clock), .reset(reset), .enable(1'b0), .load(max_upd),
    .value(latency), .count(max_latency)
  );

`ifdef UPC_LOOP_MONITOR_STALL_EN
  // Only RUN cycles count; a HOLD spent waiting on loop_continue is not a stall.
  sat_counter #(.W(CNT_W)) u_stall_cycles (
    .clock(clock), .reset(reset),
    .enable(live & run & (cur_state == iter_start_state) & iter_start_block),
    .load(1'b0), .value('0), .count(stall_cycles)
  );
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_upc_loop_monitor.sv
// Bench for upc_loop_monitor: a 32-bit and a 4-bit instance share stimulus and are
// checked every cycle against a behavioural model, plus hand-computed literals.
module tb_upc_loop_monitor;

`ifdef UPC_LOOP_MONITOR_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [1:0] cur_state, iss, ies, qs;
  logic       isb, ieb, qb, ise, iee, qe;
  logic       loop_start, loop_ready, loop_done, loop_continue, qae, finish;

  logic        a_act, a_sp, a_ep, a_qp, a_fin;
  logic [31:0] a_inv, a_st, a_en, a_last, a_max, a_stall;
  logic [7:0]  a_inf;
  logic        b_act, b_sp, b_ep, b_qp, b_fin;
  logic [3:0]  b_inv, b_st, b_en, b_last, b_max, b_stall;
  logic [7:0]  b_inf;

  upc_loop_monitor #(.STATE_W(2), .CNT_W(32)) dut_a (
    .clock(clock), .reset(reset), .cur_state(cur_state),
    .iter_start_state(iss), .iter_end_state(ies), .quit_state(qs),
    .iter_start_block(isb), .iter_end_block(ieb), .quit_block(qb),
    .iter_start_enable(ise), .iter_end_enable(iee), .quit_enable(qe),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(qae), .finish(finish),
    .active(a_act), .iter_start_p(a_sp), .iter_end_p(a_ep), .quit_p(a_qp),
    .invocations(a_inv), .iter_started(a_st), .iter_ended(a_en),
    .last_latency(a_last), .max_latency(a_max), .inflight(a_inf),
    .stall_cycles(a_stall), .finished(a_fin)
  );

  upc_loop_monitor #(.STATE_W(2), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .cur_state(cur_state),
    .iter_start_state(iss), .iter_end_state(ies), .quit_state(qs),
    .iter_start_block(isb), .iter_end_block(ieb), .quit_block(qb),
    .iter_start_enable(ise), .iter_end_enable(iee), .quit_enable(qe),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(qae), .finish(finish),
    .active(b_act), .iter_start_p(b_sp), .iter_end_p(b_ep), .quit_p(b_qp),
    .invocations(b_inv), .iter_started(b_st), .iter_ended(b_en),
    .last_latency(b_last), .max_latency(b_max), .inflight(b_inf),
    .stall_cycles(b_stall), .finished(b_fin)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: true (unbounded) counts, saturated only when compared.
  bit     m_in, m_hold, m_frz, m_fin, m_pend, m_pendc, m_s, m_e, m_done, m_cont;
  longint m_inv, m_st, m_en, m_lat, m_last, m_max, m_stall;
  int     m_inf;

  function automatic bit exp_sp();
    return m_in && (cur_state == iss) && !isb && ise;
  endfunction
  function automatic bit exp_ep();
    return m_in && (cur_state == ies) && !ieb && iee;
  endfunction
  function automatic bit exp_qp();
    return m_in && (cur_state == qs) && !qb && qe && (!qae || exp_ep());
  endfunction
  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic close_inv();
    m_last = m_lat;
    if (m_lat > m_max) m_max = m_lat;
    m_in   = 1'b0;
    m_hold = 1'b0;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      {m_in, m_hold, m_frz, m_fin, m_pend, m_pendc} = '0;
      {m_inv, m_st, m_en, m_lat, m_last, m_max, m_stall} = '0;
      m_inf = 0;
    end else if (!m_frz) begin
      if (finish) begin
        m_frz = 1'b1; m_fin = 1'b1; m_in = 1'b0; m_hold = 1'b0; m_pend = 1'b0;
      end else begin
        m_s = exp_sp();
        m_e = exp_ep();
        if (m_s) m_st++;
        if (m_e) m_en++;
        if (m_s && !m_e) m_inf = (m_inf == 255) ? 255 : m_inf + 1;
        else if (m_e && !m_s && m_inf > 0) m_inf--;
        if (m_in && !m_hold && (cur_state == iss) && isb) m_stall++;
        if (!m_in) begin
          if (loop_start) begin
            m_inv++; m_in = 1'b1; m_lat = 1; m_pend = loop_done; m_pendc = loop_continue;
          end
        end else if (!m_hold) begin
          m_done = loop_done || m_pend;
          m_cont = m_pend ? m_pendc : loop_continue;
          m_pend = 1'b0;
          if (m_done && m_cont) close_inv();
          else begin
            if (m_done) m_hold = 1'b1;
            m_lat++;
          end
        end else if (loop_continue) close_inv();
        else m_lat++;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cmp_dut(input string t, input int w, input logic act, input logic sp,
                         input logic ep, input logic qp, input longint inv, input longint st,
                         input longint en, input longint ll, input longint ml,
                         input longint stl, input logic [7:0] inf, input logic fin);
    chk({t, ".active"}, act, m_in);
    chk({t, ".iter_start_p"}, sp, exp_sp());
    chk({t, ".iter_end_p"}, ep, exp_ep());
    chk({t, ".quit_p"}, qp, exp_qp());
    chk({t, ".invocations"}, inv, sat(m_inv, w));
    chk({t, ".iter_started"}, st, sat(m_st, w));
    chk({t, ".iter_ended"}, en, sat(m_en, w));
    chk({t, ".last_latency"}, ll, sat(m_last, w));
    chk({t, ".max_latency"}, ml, sat(m_max, w));
    chk({t, ".stall_cycles"}, stl, STALL_ON ? sat(m_stall, w) : 0);
    chk({t, ".inflight"}, inf, m_inf);
    chk({t, ".finished"}, fin, m_fin);
  endtask

  always begin
    @(negedge clock);
    #1;
    cmp_dut("w32", 32, a_act, a_sp, a_ep, a_qp, a_inv, a_st, a_en, a_last, a_max, a_stall, a_inf, a_fin);
    cmp_dut("w4", 4, b_act, b_sp, b_ep, b_qp, b_inv, b_st, b_en, b_last, b_max, b_stall, b_inf, b_fin);
  end

  task automatic clk1();
    @(negedge clock);
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) clk1();
  endtask

  task automatic idle_inputs();
    cur_state = 2'd0; iss = 2'd1; ies = 2'd2; qs = 2'd2;
    isb = 1'b0; ieb = 1'b0; qb = 1'b0; ise = 1'b1; iee = 1'b1; qe = 1'b1;
    loop_start = 1'b0; loop_ready = 1'b0; loop_done = 1'b0; loop_continue = 1'b0;
    qae = 1'b0; finish = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    clk1();
    clk1();
    reset = 1'b1;
    clk1();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1 reset = 1'b0;
    clk1();
    clk1();
    chk("reset.invocations", a_inv, 0);
    chk("reset.active", a_act, 0);
    chk("reset.finished", a_fin, 0);
    chk("reset.inflight", a_inf, 0);
    reset = 1'b1;
    clk1();

    // Basic invocation: 4 starts, done+continue in the 6th RUN cycle.
    loop_start = 1'b1; clk1();
    loop_start = 1'b0; cur_state = 2'd1; cycles(4);
    cur_state = 2'd2; clk1();
    loop_done = 1'b1; loop_continue = 1'b1; clk1();
    loop_done = 1'b0; loop_continue = 1'b0; cur_state = 2'd0;
    chk("basic.invocations", a_inv, 1);
    chk("basic.iter_started", a_st, 4);
    chk("basic.last_latency", a_last, 6);
    chk("basic.active", a_act, 0);
    chk("basic.inflight", a_inf, 2);

    // Blocked iteration start for 3 RUN cycles.
    loop_start = 1'b1; clk1();
    loop_start = 1'b0; cur_state = 2'd1; isb = 1'b1;
    repeat (3) begin
      #1 chk("stall.no_start_p", a_sp, 0);
      clk1();
    end
    isb = 1'b0;
    #1 chk("stall.start_p", a_sp, 1);
    clk1();
    cur_state = 2'd0; loop_done = 1'b1; loop_continue = 1'b1; clk1();
    loop_done = 1'b0; loop_continue = 1'b0;
    chk("stall.iter_started", a_st, 5);
    chk("stall.stall_cycles", a_stall, STALL_ON ? 3 : 0);
    chk("stall.last_latency", a_last, 5);
    chk("stall.inflight", a_inf, 3);

    // Quit gating, then done with continue low for 2 cycles (HOLD).
    loop_start = 1'b1; clk1();
    loop_start = 1'b0; cur_state = 2'd2; iee = 1'b0; qae = 1'b1;
    #1 chk("quit.gated_by_end", a_qp, 0);
    clk1();
    qae = 1'b0;
    #1 chk("quit.at_start", a_qp, 1);
    clk1();
    cur_state = 2'd0; iee = 1'b1; loop_done = 1'b1; clk1();
    chk("hold.active1", a_act, 1);
    clk1();
    chk("hold.active2", a_act, 1);
    loop_continue = 1'b1; clk1();
    loop_done = 1'b0; loop_continue = 1'b0;
    chk("hold.last_latency", a_last, 5);
    chk("hold.active_after", a_act, 0);
    chk("hold.max_latency", a_max, 6);

    // loop_start and loop_done together: 1-cycle invocation.
    loop_start = 1'b1; loop_done = 1'b1; loop_continue = 1'b1; clk1();
    loop_start = 1'b0; loop_done = 1'b0; loop_continue = 1'b0; clk1();
    chk("oneshot.last_latency", a_last, 1);
    chk("oneshot.invocations", a_inv, 4);
    chk("oneshot.active", a_act, 0);

    // Latencies 5 then 3; ends on empty inflight are ignored.
    do_reset();
    loop_start = 1'b1; clk1();
    loop_start = 1'b0; cur_state = 2'd2; cycles(4);
    loop_done = 1'b1; loop_continue = 1'b1; clk1();
    loop_done = 1'b0; loop_continue = 1'b0; cur_state = 2'd0;
    chk("underflow.inflight", a_inf, 0);
    chk("underflow.iter_ended", a_en, 5);
    loop_start = 1'b1; clk1();
    loop_start = 1'b0; cycles(2);
    loop_done = 1'b1; loop_continue = 1'b1; clk1();
    loop_done = 1'b0; loop_continue = 1'b0;
    chk("two.last_latency", a_last, 3);
    chk("two.max_latency", a_max, 5);
    chk("two.invocations", a_inv, 2);

    // finish mid-run freezes everything.
    do_reset();
    loop_start = 1'b1; clk1();
    loop_start = 1'b0; cur_state = 2'd1; cycles(2);
    finish = 1'b1; clk1();
    finish = 1'b0;
    chk("freeze.finished", a_fin, 1);
    for (int i = 0; i < 10; i++) begin
      cur_state = (i % 2 == 1) ? 2'd1 : 2'd2;
      loop_start = (i == 3);
      loop_done = (i == 5);
      loop_continue = 1'b1;
      clk1();
      chk("freeze.iter_started", a_st, 2);
      chk("freeze.invocations", a_inv, 1);
      chk("freeze.iter_ended", a_en, 0);
    end

    // Saturation on the 4-bit instance, inflight at 255, then async reset mid-run.
    do_reset();
    loop_start = 1'b1; clk1();
    loop_start = 1'b0; cur_state = 2'd1;
    cycles(20);
    chk("sat.w4_iter_started", b_st, 15);
    chk("sat.w32_iter_started", a_st, 20);
    cycles(240);
    chk("sat.w32_inflight", a_inf, 255);
    chk("sat.w4_inflight", b_inf, 255);
    chk("sat.w32_iter_started_260", a_st, 260);
    #1 reset = 1'b0;
    #1;
    chk("areset.w4_iter_started", b_st, 0);
    chk("areset.w4_invocations", b_inv, 0);
    chk("areset.w4_inflight", b_inf, 0);
    chk("areset.w4_active", b_act, 0);
    chk("areset.w32_iter_started", a_st, 0);
    chk("areset.w32_active", a_act, 0);
    clk1();
    idle_inputs();
    reset = 1'b1;
    clk1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
